// File: rtl/ppi_pkg.sv
// ppi_pkg: shared definitions for the PPI bus master.
//   - PPI port address constants (A, B, C, control)
//   - bus-cycle FSM state enum
//   - 8255-style control-word constants and a bit-set/reset word builder
//   - max3: constant helper used to size the cycle timer
package ppi_pkg;

  localparam logic [1:0] PORT_A    = 2'd0;
  localparam logic [1:0] PORT_B    = 2'd1;
  localparam logic [1:0] PORT_C    = 2'd2;
  localparam logic [1:0] PORT_CTRL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IDLE_TA,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } ppi_state_t;

  // Mode-set word: mode 0, ports A/B/C all outputs.
  localparam logic [7:0] CW_MODE0_ALL_OUT = 8'h80;

  // Bit set/reset word for port C: bit7=0, bits3:1 bit index, bit0 value.
  function automatic logic [7:0] bsr_word(input logic [2:0] bit_idx, input logic value);
    return {4'b0000, bit_idx, value};
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ppi_cycle_timer.sv
// ppi_cycle_timer: loadable down-counter with zero flag. The bus master loads
// (phase length - 1) on entry to each timed phase; the phase ends on the cycle
// in which zero is high.
// Ports:
//   clk      in   clock
//   Reset    in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle
//   load_val in   W  value to load
//   zero     out  count is zero
module ppi_cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// ppi_bus_master: turns single-beat valid/ready requests into timed PPI bus
// cycles (SETUP -> STROBE -> HOLD) and returns a one-cycle response.
// Optional feature macro: PPI_TURNAROUND_EN -- when defined, a write accepted
// after a completed read gets one extra idle cycle before its bus cycle.
// Ports:
//   clk, Reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE, not in Reset)
//   req_write/addr/wdata  request fields (addr 0..2 = port A..C, 3 = control)
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    read data / read-of-control error, with rsp_valid
//   CS_low, RD_low, WR_low, PortSelect   PPI bus (strobes active low)
//   DATA_out, DATA_oe, DATA_in           split tristate data pad
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          CS_low,
  output logic          RD_low,
  output logic          WR_low,
  output logic [1:0]    PortSelect,
  output logic [DW-1:0] DATA_out,
  output logic          DATA_oe,
  input  logic [DW-1:0] DATA_in
);

`ifdef PPI_TURNAROUND_EN
  localparam bit TA_EN = 1'b1;
`else
  localparam bit TA_EN = 1'b0;
`endif

  localparam int CW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);

  localparam logic [CW-1:0] SETUP_LD  = CW'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  // First timed phase after acceptance; SETUP disappears when SETUP_CYC=0.
  localparam ppi_state_t    FIRST_ST = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;
  localparam logic [CW-1:0] FIRST_LD = (SETUP_CYC > 0) ? SETUP_LD : STROBE_LD;

  ppi_state_t state_reg, state_next;

  logic          write_reg, write_next;
  logic [1:0]    addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [DW-1:0] rdata_reg, rdata_next;
  logic          last_read_reg, last_read_next;

  logic          cs_low_reg, cs_low_next;
  logic          rd_low_reg, rd_low_next;
  logic          wr_low_reg, wr_low_next;
  logic [1:0]    port_sel_reg, port_sel_next;
  logic [DW-1:0] data_out_reg, data_out_next;
  logic          data_oe_reg, data_oe_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic          rsp_err_reg, rsp_err_next;

  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_zero;
  logic          done;
  logic          active_next;
  logic          strobe_next;

  ppi_cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .Reset    (Reset),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  assign req_ready = (state_reg == ST_IDLE) && !Reset;

  always_comb begin
    state_next     = state_reg;
    write_next     = write_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    last_read_next = last_read_reg;
    timer_load     = 1'b0;
    timer_val      = '0;
    done           = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          write_next = req_write;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          if (TA_EN && req_write && last_read_reg) begin
            state_next = ST_IDLE_TA;
          end else begin
            state_next = FIRST_ST;
            timer_load = 1'b1;
            timer_val  = FIRST_LD;
          end
        end
      end
      ST_IDLE_TA: begin
        state_next = FIRST_ST;
        timer_load = 1'b1;
        timer_val  = FIRST_LD;
      end
      ST_SETUP: begin
        if (timer_zero) begin
          state_next = ST_STROBE;
          timer_load = 1'b1;
          timer_val  = STROBE_LD;
        end
      end
      ST_STROBE: begin
        if (timer_zero) begin
          // Sample the pad on the last strobe cycle, while RD_low is still low.
          if (!write_reg) begin
            rdata_next = DATA_in;
          end
          if (HOLD_CYC > 0) begin
            state_next = ST_HOLD;
            timer_load = 1'b1;
            timer_val  = HOLD_LD;
          end else begin
            state_next = ST_IDLE;
            done       = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (done) begin
      last_read_next = !write_reg;
    end

    // Bus outputs are registered from the next state so they line up exactly
    // with the cycles the FSM spends in each phase.
    active_next   = (state_next == ST_SETUP) || (state_next == ST_STROBE) ||
                    (state_next == ST_HOLD);
    strobe_next   = (state_next == ST_STROBE);
    cs_low_next   = !active_next;
    port_sel_next = active_next ? addr_next : 2'd0;
    data_oe_next  = active_next && write_next;
    data_out_next = data_oe_next ? wdata_next : '0;
    wr_low_next   = !(strobe_next && write_next);
    // The control register is write-only: a read of it runs the cycle without RD.
    rd_low_next   = !(strobe_next && !write_next && (addr_next != PORT_CTRL));

    rsp_valid_next = done;
    rsp_err_next   = done && !write_reg && (addr_reg == PORT_CTRL);
    rsp_rdata_next = (done && !write_reg && (addr_reg != PORT_CTRL)) ? rdata_next : '0;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg     <= ST_IDLE;
      write_reg     <= 1'b0;
      addr_reg      <= 2'd0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      last_read_reg <= 1'b0;
      cs_low_reg    <= 1'b1;
      rd_low_reg    <= 1'b1;
      wr_low_reg    <= 1'b1;
      port_sel_reg  <= 2'd0;
      data_out_reg  <= '0;
      data_oe_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      write_reg     <= write_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      last_read_reg <= last_read_next;
      cs_low_reg    <= cs_low_next;
      rd_low_reg    <= rd_low_next;
      wr_low_reg    <= wr_low_next;
      port_sel_reg  <= port_sel_next;
      data_out_reg  <= data_out_next;
      data_oe_reg   <= data_oe_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_err_reg   <= rsp_err_next;
    end
  end

  assign CS_low     = cs_low_reg;
  assign RD_low     = rd_low_reg;
  assign WR_low     = wr_low_reg;
  assign PortSelect = port_sel_reg;
  assign DATA_out   = data_out_reg;
  assign DATA_oe    = data_oe_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_rdata  = rsp_rdata_reg;
  assign rsp_err    = rsp_err_reg;

endmodule

// File: tb/tb_ppi_bus_master.sv
// tb_ppi_bus_master: two instances -- default timing (dut0) and
// SETUP=0/STROBE=1/HOLD=0 (dut1). A cycle-indexed model derived from phase
// lengths predicts every output each cycle; a table of literal values pins
// key cycles. Honours PPI_TURNAROUND_EN when compiled with it.
module tb_ppi_bus_master;
  import ppi_pkg::*;

`ifdef PPI_TURNAROUND_EN
  localparam int TA_EN = 1;
`else
  localparam int TA_EN = 0;
`endif

  localparam int NC  = 64;
  localparam int END = 48;
  localparam int NS  = 10;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic       Reset [2];
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [1:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err [2];
  logic       CS_low [2];
  logic       RD_low [2];
  logic       WR_low [2];
  logic [1:0] PortSelect [2];
  logic [7:0] DATA_out [2];
  logic       DATA_oe [2];
  logic [7:0] DATA_in [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      ppi_bus_master #(
        .SETUP_CYC  ((gi == 0) ? 1 : 0),
        .STROBE_CYC ((gi == 0) ? 2 : 1),
        .HOLD_CYC   ((gi == 0) ? 1 : 0),
        .DW         (8)
      ) u_dut (
        .clk        (clk),
        .Reset      (Reset[gi]),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_write  (req_write[gi]),
        .req_addr   (req_addr[gi]),
        .req_wdata  (req_wdata[gi]),
        .rsp_valid  (rsp_valid[gi]),
        .rsp_rdata  (rsp_rdata[gi]),
        .rsp_err    (rsp_err[gi]),
        .CS_low     (CS_low[gi]),
        .RD_low     (RD_low[gi]),
        .WR_low     (WR_low[gi]),
        .PortSelect (PortSelect[gi]),
        .DATA_out   (DATA_out[gi]),
        .DATA_oe    (DATA_oe[gi]),
        .DATA_in    (DATA_in[gi])
      );
    end
  endgenerate

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Signal ids: 0 ready, 1 CS, 2 RD, 3 WR, 4 PortSelect, 5 OE, 6 DATA_out,
  // 7 rsp_valid, 8 rsp_err, 9 rsp_rdata
  string sig_name [NS] = '{"req_ready", "CS_low", "RD_low", "WR_low", "PortSelect",
                           "DATA_oe", "DATA_out", "rsp_valid", "rsp_err", "rsp_rdata"};

  int exp_v [2][NC][NS];
  int st_v [2][NC];
  int st_w [2][NC];
  int st_a [2][NC];
  int st_d [2][NC];
  int st_rst [2][NC];
  int st_din [2][NC];
  int s_cyc [2];
  int t_cyc [2];
  int h_cyc [2];
  int last_read [2];

  typedef struct {
    int k;
    int c;
    int s;
    int v;
  } pin_t;
  pin_t pins [$];

  function automatic int get_sig(int k, int s);
    case (s)
      0: return int'(req_ready[k]);
      1: return int'(CS_low[k]);
      2: return int'(RD_low[k]);
      3: return int'(WR_low[k]);
      4: return int'(PortSelect[k]);
      5: return int'(DATA_oe[k]);
      6: return int'(DATA_out[k]);
      7: return int'(rsp_valid[k]);
      8: return int'(rsp_err[k]);
      default: return int'(rsp_rdata[k]);
    endcase
  endfunction

  task automatic set_idle(int k, int c);
    exp_v[k][c][0] = 1;
    exp_v[k][c][1] = 1;
    exp_v[k][c][2] = 1;
    exp_v[k][c][3] = 1;
    for (int s = 4; s < NS; s++) exp_v[k][c][s] = 0;
  endtask

  // Request accepted in cycle a: bus active for S+T+H cycles starting a+1
  // (+1 for a write right after a read when turnaround is on), response next.
  task automatic sched(int k, int a, int w, int ad, int d, int dv);
    int ta, base, n, c;
    bit strb;
    ta = (TA_EN != 0 && w != 0 && last_read[k] != 0) ? 1 : 0;
    base = a + ta;
    n = s_cyc[k] + t_cyc[k] + h_cyc[k];
    st_v[k][a] = 1;
    st_w[k][a] = w;
    st_a[k][a] = ad;
    st_d[k][a] = d;
    for (int i = a + 1; i <= base + n; i++) exp_v[k][i][0] = 0;
    for (int r = 1; r <= n; r++) begin
      c = base + r;
      strb = (r > s_cyc[k]) && (r <= s_cyc[k] + t_cyc[k]);
      exp_v[k][c][1] = 0;
      exp_v[k][c][4] = ad;
      exp_v[k][c][5] = w;
      exp_v[k][c][6] = (w != 0) ? d : 0;
      exp_v[k][c][2] = (strb && w == 0 && ad != 3) ? 0 : 1;
      exp_v[k][c][3] = (strb && w != 0) ? 0 : 1;
      if (strb && w == 0)
        st_din[k][c] = (r == s_cyc[k] + t_cyc[k]) ? dv : (~dv & 8'hFF);
    end
    c = base + n + 1;
    exp_v[k][c][7] = 1;
    exp_v[k][c][8] = (w == 0 && ad == 3) ? 1 : 0;
    exp_v[k][c][9] = (w == 0 && ad != 3) ? dv : 0;
    last_read[k] = (w == 0) ? 1 : 0;
  endtask

  // Reset sampled at the edges ending cycles r0..r1: outputs idle from r0+1,
  // no ready while Reset is high.
  task automatic rst_at(int k, int r0, int r1);
    for (int c = r0 + 1; c < NC; c++) set_idle(k, c);
    for (int c = r0; c <= r1; c++) begin
      st_rst[k][c] = 1;
      exp_v[k][c][0] = 0;
    end
    last_read[k] = 0;
  endtask

  task automatic pin(int k, int c, int s, int v);
    pin_t p;
    p.k = k;
    p.c = c;
    p.s = s;
    p.v = v;
    pins.push_back(p);
  endtask

  task automatic build_model();
    s_cyc[0] = 1; t_cyc[0] = 2; h_cyc[0] = 1;
    s_cyc[1] = 0; t_cyc[1] = 1; h_cyc[1] = 0;
    for (int k = 0; k < 2; k++) begin
      last_read[k] = 0;
      for (int c = 0; c < NC; c++) begin
        set_idle(k, c);
        st_v[k][c] = 0; st_w[k][c] = 0; st_a[k][c] = 0; st_d[k][c] = 0;
        st_rst[k][c] = 0; st_din[k][c] = 8'hEE;
      end
      rst_at(k, 0, 2);
    end
    // dut0: default timing
    sched(0, 4, 1, 3, CW_MODE0_ALL_OUT, 0);
    sched(0, 9, 0, 1, 0, 8'h99);
    sched(0, 16, 0, 3, 0, 8'h42);
    sched(0, 21, 1, 2, 8'h5A, 0);
    sched(0, 30, 1, 0, 8'h3C, 0);
    rst_at(0, 32, 32);
    sched(0, 34, 0, 2, 0, 8'hC3);
    // dut1: no setup/hold, single-cycle strobe
    sched(1, 4, 1, 0, 8'h11, 0);
    sched(1, 6, 1, 1, 8'h22, 0);
    sched(1, 10, 0, 2, 0, 8'h77);
    sched(1, 12, 1, 1, 8'h44, 0);
    sched(1, 20, 0, 3, 0, 8'h42);

    // Literal expectations pinning the model
    pin(0, 1, 1, 1);  pin(0, 1, 0, 0);  pin(0, 3, 0, 1);  pin(0, 3, 5, 0);
    pin(0, 5, 1, 0);  pin(0, 8, 1, 0);  pin(0, 9, 1, 1);  pin(0, 5, 3, 1);
    pin(0, 6, 3, 0);  pin(0, 7, 3, 0);  pin(0, 8, 3, 1);  pin(0, 5, 5, 1);
    pin(0, 8, 5, 1);  pin(0, 5, 6, 8'h80); pin(0, 9, 7, 1); pin(0, 9, 8, 0);
    pin(0, 11, 2, 0); pin(0, 12, 2, 0); pin(0, 13, 2, 1); pin(0, 14, 9, 8'h99);
    pin(0, 18, 2, 1); pin(0, 18, 1, 0); pin(0, 21, 7, 1); pin(0, 21, 8, 1);
    pin(0, 21, 9, 0); pin(0, 33, 1, 1); pin(0, 33, 3, 1); pin(0, 33, 5, 0);
    pin(0, 35, 7, 0); pin(0, 39, 9, 8'hC3);
    pin(1, 5, 3, 0);  pin(1, 6, 3, 1);  pin(1, 7, 3, 0);  pin(1, 7, 4, 1);
    pin(1, 6, 7, 1);  pin(1, 8, 7, 1);  pin(1, 12, 9, 8'h77); pin(1, 21, 2, 1);
    pin(1, 22, 8, 1);
    if (TA_EN != 0) begin
      pin(0, 22, 1, 1); pin(0, 22, 0, 0); pin(0, 27, 7, 1); pin(0, 26, 7, 0);
    end else begin
      pin(0, 22, 1, 0); pin(0, 26, 7, 1); pin(0, 27, 7, 0);
    end
  endtask

  task automatic apply(int c);
    for (int k = 0; k < 2; k++) begin
      if (c < NC) begin
        Reset[k]     = (st_rst[k][c] != 0);
        req_valid[k] = (st_v[k][c] != 0);
        req_write[k] = (st_w[k][c] != 0);
        req_addr[k]  = 2'(st_a[k][c]);
        req_wdata[k] = 8'(st_d[k][c]);
        DATA_in[k]   = 8'(st_din[k][c]);
      end else begin
        Reset[k] = 1'b0; req_valid[k] = 1'b0; req_write[k] = 1'b0;
        req_addr[k] = 2'd0; req_wdata[k] = 8'h00; DATA_in[k] = 8'hEE;
      end
    end
  endtask

  // Compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= END) begin
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < NS; s++) begin
          if (s < 8 || exp_v[k][cyc][7] != 0) begin
            checks++;
            if (get_sig(k, s) != exp_v[k][cyc][s]) begin
              errors++;
              $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                       sig_name[s], k, cyc, get_sig(k, s), exp_v[k][cyc][s]);
            end
          end
        end
        if (rsp_valid[k] === 1'b1)
          $display("dut%0d cycle %0d response rdata=%02h err=%0d",
                   k, cyc, rsp_rdata[k], rsp_err[k]);
      end
      foreach (pins[i]) begin
        if (pins[i].c == cyc) begin
          checks++;
          if (get_sig(pins[i].k, pins[i].s) != pins[i].v) begin
            errors++;
            $display("FAIL pin_%s dut%0d cycle %0d: got %0h expected %0h",
                     sig_name[pins[i].s], pins[i].k, cyc,
                     get_sig(pins[i].k, pins[i].s), pins[i].v);
          end
        end
      end
    end
  end

  initial begin
    build_model();
    apply(0);
    while (cyc < END) begin
      @(posedge clk);
      #1;
      apply(cyc);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
